vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Run-time programmable VGA timing generator. Successor to the fixed-mode sync block.
//  Produces hsync/vsync with selectable polarity, video_on, and pixel X/Y coordinates.
//  Also produces frame and line strobes. Feeds the pixel fetch/colour path.
//  Timing is reloadable from a CSR interface; a new timing takes effect only at a frame boundary.
// PARAMETERS
//  HW        12   width of horizontal segment/config fields and pixel_x
//  VW        11   width of vertical segment/config fields and pixel_y
//  HVA_DEF   640  reset horizontal visible; HFP_DEF 16, HSP_DEF 96, HBP_DEF 48
//  VVA_DEF   480  reset vertical visible;   VFP_DEF 10, VSP_DEF 2,  VBP_DEF 33
//  HS_POL    0    hsync active level (0 = active-low)
//  VS_POL    0    vsync active level (0 = active-low)
//  PIPE_DLY  1    extra register stages on all outputs, 0..4, to align with pixel pipeline
// PORTS
//  clk_vga      in   1     pixel clock; one clock domain, no CDC inside
//  rst_vga_n    in   1     reset, synchronous, active-low
//  cfg_hva/hfp/hsp/hbp in HW  pending horizontal segment lengths, in pixels
//  cfg_vva/vfp/vsp/vbp in VW  pending vertical segment lengths, in lines
//  cfg_load     in   1     1-cycle pulse; captures all cfg_* into the shadow set
//  cfg_busy     out  1     shadow set captured but not yet applied
//  cfg_err      out  1     1-cycle pulse: cfg_load rejected because a field was 0
//  vga_hsync    out  1     horizontal sync, level per HS_POL
//  vga_vsync    out  1     vertical sync, level per VS_POL
//  vga_video_on out  1     inside visible area
//  pixel_x      out  HW    column 0..HVA-1 when video_on, else 0
//  pixel_y      out  VW    row 0..VVA-1 when video_on, else 0
//  first_pixel  out  1     pulse with pixel (0,0)
//  line_start   out  1     pulse with pixel_x==0 of each visible line
//  frame_end    out  1     pulse on the last cycle of the frame (last cycle of vertical FP)
// BEHAVIOUR
//  - Per axis, the state sequence is SP->BP->VA->FP->SP. The state is one-hot, from vga_timing_pkg.
//  - The per-state counter runs 0..LEN-1 and then wraps to 0 with a state advance.
//  - The vertical axis advances only on h_tick, the last cycle of horizontal FP.
//  - Reset (rst_vga_n==0 on a clock edge): both axes go to SP with count 0, and the active set loads the *_DEF values.
//  - Reset also clears the pipeline: syncs inactive, video_on/first_pixel/line_start/frame_end = 0, pixel_x/y = 0.
//  - Reset also clears the status outputs: cfg_busy = 0, cfg_err = 0.
//  - Reset mid-frame aborts the frame immediately. Any pending shadow set is discarded.
//  - Latency: outputs are registered 1 cycle after the state/counter, plus PIPE_DLY stages. All outputs share identical latency.
//  - pixel_x/pixel_y are the VA counters, gated to 0 outside the visible area.
//  - cfg_load with any field == 0: the load is rejected, cfg_err pulses the next cycle, and cfg_busy is unchanged.
//  - Valid cfg_load: the shadow set is captured and cfg_busy = 1 from the next cycle.
//  - A cfg_load while busy overwrites the shadow set; the last valid load wins.
//  - Apply point: the cycle where the vertical state is FP, the vertical count is VFP-1, and h_tick is high. This is the frame_end condition.
//  - At the apply point, the active set <= shadow set and cfg_busy drops on the next cycle. The next frame fully uses the new timing.
//  - Simultaneous cfg_load and apply point: the old shadow set is applied. The new load is captured and cfg_busy stays 1.
//  - Counters are compared with ==LEN-1 only. Widths are HW/VW, with no carry beyond the field width.
// CONFIGURATION
//  VGA_ADV7123_EN defined: adds the DAC ports adv7123_vga_blank (registered hsync_active_n&vsync_active_n, reset 1),
//    adv7123_vga_sync (=0), and adv7123_vga_clk (=clk_vga). The blank output is delayed to match the other outputs.
//  VGA_ADV7123_EN undefined: these ports and their logic are absent.
// STRUCTURE
//  vga_timing_pkg.vh: state encodings SP/BP/VA/FP, *_DEF constants for 640x480@60, and a PIPE_DLY max macro.
//  Sub-module vga_axis_seq (#W): one axis state machine plus counter. Inputs are en and len_{va,fp,sp,bp}.
//    Outputs are state, count, and last (end of FP). It is instantiated twice, with the H last output feeding the V en input.
//  The top level holds the shadow/active config registers, the output gating, and the PIPE_DLY shift chain.
// TESTING (tiny timing HVA4 HFP1 HSP2 HBP1 / VVA3 VFP1 VSP1 VBP1: 8 clk/line, 48 clk/frame)
//  1 Reset release, PIPE_DLY=0: hsync low for clk 1-2. video_on first high at clk 1+48-? -- pixel (0,0) occurs at
//    line 2 col 3 -> first_pixel at clk 2*8+3+1=20, pixel_x 0,1,2,3 then video_on low.
//  2 Full frame: exactly 12 video_on cycles, 3 line_start pulses, 1 first_pixel pulse, and frame_end every 48 clk.
//  3 cfg_load HVA=8 mid-frame: cfg_busy=1 until frame_end+1. The current frame stays at 8 clk/line, and the next frame is at 12 clk/line.
//  4 cfg_load with cfg_vsp=0: cfg_err pulses once, cfg_busy stays 0, and the timing is unchanged.
//  5 cfg_load on the exact frame_end cycle while a prior load is pending: the prior set is applied and the new set applies one frame later.
//  6 rst_vga_n low for 1 clk mid-VA: the next cycle shows syncs inactive, video_on 0, and cfg_busy 0. The sequence restarts as in test 1.
//    HS_POL=1 rerun: hsync is high during SP.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// ----------------------------------------------------------------------------
// vga_timing_pkg
//   Shared definitions for the programmable VGA timing generator:
//   - one-hot per-axis segment state (SP -> BP -> VA -> FP -> SP)
//   - reset timing for 640x480@60 (25.175 MHz pixel clock)
//   - upper bound for the output alignment pipeline depth
//   - next_state(): segment order shared by both axes
// Ports: none (package).
// ----------------------------------------------------------------------------
package vga_timing_pkg;

   typedef enum logic [3:0] {
      ST_SP = 4'b0001,   // sync pulse
      ST_BP = 4'b0010,   // back porch
      ST_VA = 4'b0100,   // visible area
      ST_FP = 4'b1000    // front porch
   } axis_state_e;

   localparam int HVA_DEF_C = 640;
   localparam int HFP_DEF_C = 16;
   localparam int HSP_DEF_C = 96;
   localparam int HBP_DEF_C = 48;
   localparam int VVA_DEF_C = 480;
   localparam int VFP_DEF_C = 10;
   localparam int VSP_DEF_C = 2;
   localparam int VBP_DEF_C = 33;

   localparam int PIPE_DLY_MAX = 4;

   function automatic axis_state_e next_state(input axis_state_e s);
      case (s)
         ST_SP:   return ST_BP;
         ST_BP:   return ST_VA;
         ST_VA:   return ST_FP;
         default: return ST_SP;   // FP, and recovery from any non-one-hot value
      endcase
   endfunction

endpackage

// File: rtl/vga_axis_seq.sv
// ----------------------------------------------------------------------------
// vga_axis_seq
//   One timing axis: segment state machine plus a per-segment counter.
//   The counter runs 0..LEN-1 of the current segment, then wraps to 0 and the
//   state advances. Nothing moves unless en_i is high.
// Ports:
//   clk_i      clock
//   rst_n_i    synchronous active-low reset (state SP, count 0)
//   en_i       advance enable (1 for horizontal, h_tick for vertical)
//   len_*_i    segment lengths, each must be non-zero
//   state_o    current one-hot segment
//   count_o    position inside the current segment
//   last_o     high on the enabled cycle that ends the front porch
// ----------------------------------------------------------------------------
module vga_axis_seq
   import vga_timing_pkg::*;
#(
   parameter int W = 12
) (
   input  logic         clk_i,
   input  logic         rst_n_i,
   input  logic         en_i,
   input  logic [W-1:0] len_va_i,
   input  logic [W-1:0] len_fp_i,
   input  logic [W-1:0] len_sp_i,
   input  logic [W-1:0] len_bp_i,
   output axis_state_e  state_o,
   output logic [W-1:0] count_o,
   output logic         last_o
);

   axis_state_e  state_q, state_d;
   logic [W-1:0] count_q, count_d;
   logic [W-1:0] len_cur;
   logic         at_end;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of its peers; blocking here would create ordering races.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q <= ST_SP;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
      end
   end

   // NOTE: every output of this block gets a default first, so no path can
   // leave a signal unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      case (state_q)
         ST_BP:   len_cur = len_bp_i;
         ST_VA:   len_cur = len_va_i;
         ST_FP:   len_cur = len_fp_i;
         default: len_cur = len_sp_i;
      endcase
      // Exact compare only; lengths are never zero so LEN-1 cannot underflow.
      at_end = (count_q == len_cur - W'(1));
      if (en_i) begin
         if (at_end) begin
            count_d = '0;
            state_d = next_state(state_q);
         end else begin
            count_d = count_q + W'(1);
         end
      end
   end

   assign state_o = state_q;
   assign count_o = count_q;
   assign last_o  = en_i && (state_q == ST_FP) && at_end;

endmodule

// File: rtl/vga_timing_gen.sv
// ----------------------------------------------------------------------------
// vga_timing_gen
//   Run-time programmable VGA timing generator. Two vga_axis_seq instances
//   (H free-running, V stepped by the H end-of-line tick), a shadow/active
//   configuration pair that swaps only at the frame boundary, output gating,
//   and a PIPE_DLY-deep alignment chain shared by every timing output.
// Build option: define VGA_ADV7123_EN to add the ADV7123 DAC control ports.
// Ports:
//   clk_vga, rst_vga_n         pixel clock, synchronous active-low reset
//   cfg_h*/cfg_v*              pending segment lengths (pixels / lines)
//   cfg_load                   capture cfg_* into the shadow set
//   cfg_busy                   shadow set waiting for the next frame boundary
//   cfg_err                    one-cycle pulse: load rejected (a field was 0)
//   vga_hsync, vga_vsync       sync outputs, active level per HS_POL/VS_POL
//   vga_video_on               visible area
//   pixel_x, pixel_y           visible coordinates, 0 outside visible area
//   first_pixel, line_start    pulses at pixel (0,0) / column 0 of each line
//   frame_end                  pulse on the last cycle of the frame
//   adv7123_vga_*              DAC blank/sync/clk (VGA_ADV7123_EN only)
// ----------------------------------------------------------------------------
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int HW       = 12,
   parameter int VW       = 11,
   parameter int HVA_DEF  = HVA_DEF_C,
   parameter int HFP_DEF  = HFP_DEF_C,
   parameter int HSP_DEF  = HSP_DEF_C,
   parameter int HBP_DEF  = HBP_DEF_C,
   parameter int VVA_DEF  = VVA_DEF_C,
   parameter int VFP_DEF  = VFP_DEF_C,
   parameter int VSP_DEF  = VSP_DEF_C,
   parameter int VBP_DEF  = VBP_DEF_C,
   parameter int HS_POL   = 0,
   parameter int VS_POL   = 0,
   parameter int PIPE_DLY = 1        // 0..PIPE_DLY_MAX
) (
   input  logic          clk_vga,
   input  logic          rst_vga_n,
   input  logic [HW-1:0] cfg_hva,
   input  logic [HW-1:0] cfg_hfp,
   input  logic [HW-1:0] cfg_hsp,
   input  logic [HW-1:0] cfg_hbp,
   input  logic [VW-1:0] cfg_vva,
   input  logic [VW-1:0] cfg_vfp,
   input  logic [VW-1:0] cfg_vsp,
   input  logic [VW-1:0] cfg_vbp,
   input  logic          cfg_load,
   output logic          cfg_busy,
   output logic          cfg_err,
   output logic          vga_hsync,
   output logic          vga_vsync,
   output logic          vga_video_on,
   output logic [HW-1:0] pixel_x,
   output logic [VW-1:0] pixel_y,
   output logic          first_pixel,
   output logic          line_start,
   output logic          frame_end
`ifdef VGA_ADV7123_EN
   ,
   output logic          adv7123_vga_blank,
   output logic          adv7123_vga_sync,
   output logic          adv7123_vga_clk
`endif
);

   typedef struct packed {
      logic [HW-1:0] hva, hfp, hsp, hbp;
      logic [VW-1:0] vva, vfp, vsp, vbp;
   } cfg_t;

   typedef struct packed {
      logic          hsync;
      logic          vsync;
      logic          video_on;
      logic [HW-1:0] px;
      logic [VW-1:0] py;
      logic          first;
      logic          line;
      logic          fend;
`ifdef VGA_ADV7123_EN
      logic          blank;
`endif
   } out_t;

   localparam logic HS_ACT = (HS_POL != 0);
   localparam logic VS_ACT = (VS_POL != 0);

   localparam cfg_t CFG_DEF = '{
      hva: HW'(HVA_DEF), hfp: HW'(HFP_DEF), hsp: HW'(HSP_DEF), hbp: HW'(HBP_DEF),
      vva: VW'(VVA_DEF), vfp: VW'(VFP_DEF), vsp: VW'(VSP_DEF), vbp: VW'(VBP_DEF)
   };

   cfg_t          act_q, act_d, shd_q, shd_d, cfg_in;
   logic          busy_q, busy_d, err_q, err_d, cfg_ok;
   axis_state_e   h_state, v_state;
   logic [HW-1:0] h_count;
   logic [VW-1:0] v_count;
   logic          h_tick, v_last;
   out_t          stage_d;
   out_t          pipe_q [0:PIPE_DLY];
   logic          h_sp, v_sp, vis;

   vga_axis_seq #(.W(HW)) u_h_axis (
      .clk_i   (clk_vga),
      .rst_n_i (rst_vga_n),
      .en_i    (1'b1),
      .len_va_i(act_q.hva),
      .len_fp_i(act_q.hfp),
      .len_sp_i(act_q.hsp),
      .len_bp_i(act_q.hbp),
      .state_o (h_state),
      .count_o (h_count),
      .last_o  (h_tick)
   );

   vga_axis_seq #(.W(VW)) u_v_axis (
      .clk_i   (clk_vga),
      .rst_n_i (rst_vga_n),
      .en_i    (h_tick),
      .len_va_i(act_q.vva),
      .len_fp_i(act_q.vfp),
      .len_sp_i(act_q.vsp),
      .len_bp_i(act_q.vbp),
      .state_o (v_state),
      .count_o (v_count),
      .last_o  (v_last)
   );

   // Config: v_last is the apply point (last cycle of the frame). The apply
   // uses the pre-edge shadow, so a load on that same cycle lands one frame later.
   always_comb begin
      cfg_in = '{hva: cfg_hva, hfp: cfg_hfp, hsp: cfg_hsp, hbp: cfg_hbp,
                 vva: cfg_vva, vfp: cfg_vfp, vsp: cfg_vsp, vbp: cfg_vbp};
      cfg_ok = (cfg_hva != '0) && (cfg_hfp != '0) && (cfg_hsp != '0) && (cfg_hbp != '0) &&
               (cfg_vva != '0) && (cfg_vfp != '0) && (cfg_vsp != '0) && (cfg_vbp != '0);
      act_d  = act_q;
      shd_d  = shd_q;
      busy_d = busy_q;
      err_d  = 1'b0;
      if (v_last && busy_q) begin
         act_d  = shd_q;
         busy_d = 1'b0;
      end
      if (cfg_load) begin
         if (cfg_ok) begin
            shd_d  = cfg_in;
            busy_d = 1'b1;
         end else begin
            err_d  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_vga) begin
      if (!rst_vga_n) begin
         act_q  <= CFG_DEF;
         shd_q  <= CFG_DEF;
         busy_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         act_q  <= act_d;
         shd_q  <= shd_d;
         busy_q <= busy_d;
         err_q  <= err_d;
      end
   end

   always_comb begin
      h_sp           = (h_state == ST_SP);
      v_sp           = (v_state == ST_SP);
      vis            = (h_state == ST_VA) && (v_state == ST_VA);
      stage_d        = '0;
      stage_d.hsync  = h_sp ? HS_ACT : ~HS_ACT;
      stage_d.vsync  = v_sp ? VS_ACT : ~VS_ACT;
      stage_d.video_on = vis;
      stage_d.px     = vis ? h_count : '0;
      stage_d.py     = vis ? v_count : '0;
      stage_d.first  = vis && (h_count == '0) && (v_count == '0);
      stage_d.line   = vis && (h_count == '0);
      stage_d.fend   = v_last;
`ifdef VGA_ADV7123_EN
      stage_d.blank  = ~h_sp & ~v_sp;
`endif
   end

   // NOTE: the alignment chain is reset, not left as plain storage, because a
   // mid-frame reset must flush stale syncs and strobes out of every stage.
   always_ff @(posedge clk_vga) begin
      if (!rst_vga_n) begin
         for (int i = 0; i <= PIPE_DLY; i++) begin
            pipe_q[i]       <= '0;
            pipe_q[i].hsync <= ~HS_ACT;
            pipe_q[i].vsync <= ~VS_ACT;
`ifdef VGA_ADV7123_EN
            pipe_q[i].blank <= 1'b1;
`endif
         end
      end else begin
         pipe_q[0] <= stage_d;
         for (int i = 1; i <= PIPE_DLY; i++) begin
            pipe_q[i] <= pipe_q[i-1];
         end
      end
   end

   assign cfg_busy     = busy_q;
   assign cfg_err      = err_q;
   assign vga_hsync    = pipe_q[PIPE_DLY].hsync;
   assign vga_vsync    = pipe_q[PIPE_DLY].vsync;
   assign vga_video_on = pipe_q[PIPE_DLY].video_on;
   assign pixel_x      = pipe_q[PIPE_DLY].px;
   assign pixel_y      = pipe_q[PIPE_DLY].py;
   assign first_pixel  = pipe_q[PIPE_DLY].first;
   assign line_start   = pipe_q[PIPE_DLY].line;
   assign frame_end    = pipe_q[PIPE_DLY].fend;

`ifdef VGA_ADV7123_EN
   assign adv7123_vga_blank = pipe_q[PIPE_DLY].blank;
   assign adv7123_vga_sync  = 1'b0;
   assign adv7123_vga_clk   = clk_vga;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// ----------------------------------------------------------------------------
// tb_vga_timing_gen
//   Directed bench for vga_timing_gen using a tiny timing
//   (H: VA4 FP1 SP2 BP1 = 8 clk/line, V: VA3 FP1 SP1 BP1 = 6 lines, 48 clk/frame).
//   dut   : PIPE_DLY=0, active-low syncs.
//   dut_p : PIPE_DLY=2, active-high syncs (shares all inputs).
//   "clk n" = value sampled on the falling edge after the n-th rising edge
//   following the last reset edge.
// ----------------------------------------------------------------------------
module tb_vga_timing_gen;

   localparam int HW = 12;
   localparam int VW = 11;

   logic          clk_vga = 1'b0;
   logic          rst_vga_n;
   logic [HW-1:0] cfg_hva, cfg_hfp, cfg_hsp, cfg_hbp;
   logic [VW-1:0] cfg_vva, cfg_vfp, cfg_vsp, cfg_vbp;
   logic          cfg_load;

   logic          busy, err, hs, vs, von, fp, ls, fe;
   logic [HW-1:0] px;
   logic [VW-1:0] py;

   logic          p_busy, p_err, p_hs, p_vs, p_von, p_fp, p_ls, p_fe;
   logic [HW-1:0] p_px;
   logic [VW-1:0] p_py;

   int checks = 0;
   int errors = 0;
   int clk_n  = 0;

   always #5 clk_vga = ~clk_vga;

   vga_timing_gen #(
      .HW(HW), .VW(VW),
      .HVA_DEF(4), .HFP_DEF(1), .HSP_DEF(2), .HBP_DEF(1),
      .VVA_DEF(3), .VFP_DEF(1), .VSP_DEF(1), .VBP_DEF(1),
      .HS_POL(0), .VS_POL(0), .PIPE_DLY(0)
   ) dut (
      .clk_vga(clk_vga), .rst_vga_n(rst_vga_n),
      .cfg_hva(cfg_hva), .cfg_hfp(cfg_hfp), .cfg_hsp(cfg_hsp), .cfg_hbp(cfg_hbp),
      .cfg_vva(cfg_vva), .cfg_vfp(cfg_vfp), .cfg_vsp(cfg_vsp), .cfg_vbp(cfg_vbp),
      .cfg_load(cfg_load), .cfg_busy(busy), .cfg_err(err),
      .vga_hsync(hs), .vga_vsync(vs), .vga_video_on(von),
      .pixel_x(px), .pixel_y(py),
      .first_pixel(fp), .line_start(ls), .frame_end(fe)
   );

   vga_timing_gen #(
      .HW(HW), .VW(VW),
      .HVA_DEF(4), .HFP_DEF(1), .HSP_DEF(2), .HBP_DEF(1),
      .VVA_DEF(3), .VFP_DEF(1), .VSP_DEF(1), .VBP_DEF(1),
      .HS_POL(1), .VS_POL(1), .PIPE_DLY(2)
   ) dut_p (
      .clk_vga(clk_vga), .rst_vga_n(rst_vga_n),
      .cfg_hva(cfg_hva), .cfg_hfp(cfg_hfp), .cfg_hsp(cfg_hsp), .cfg_hbp(cfg_hbp),
      .cfg_vva(cfg_vva), .cfg_vfp(cfg_vfp), .cfg_vsp(cfg_vsp), .cfg_vbp(cfg_vbp),
      .cfg_load(cfg_load), .cfg_busy(p_busy), .cfg_err(p_err),
      .vga_hsync(p_hs), .vga_vsync(p_vs), .vga_video_on(p_von),
      .pixel_x(p_px), .pixel_y(p_py),
      .first_pixel(p_fp), .line_start(p_ls), .frame_end(p_fe)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance to the falling edge after rising edge number n (n > clk_n).
   task automatic goto(input int n);
      while (clk_n < n) begin
         @(posedge clk_vga);
         clk_n++;
      end
      @(negedge clk_vga);
   endtask

   task automatic set_cfg(input int hva, input int hfp, input int hsp, input int hbp,
                          input int vva, input int vfp, input int vsp, input int vbp);
      cfg_hva = HW'(hva); cfg_hfp = HW'(hfp); cfg_hsp = HW'(hsp); cfg_hbp = HW'(hbp);
      cfg_vva = VW'(vva); cfg_vfp = VW'(vfp); cfg_vsp = VW'(vsp); cfg_vbp = VW'(vbp);
   endtask

   int n_von, n_ls, n_fp, n_fe;

   initial begin
      rst_vga_n = 1'b0;
      cfg_load  = 1'b0;
      set_cfg(0, 0, 0, 0, 0, 0, 0, 0);
      repeat (3) @(posedge clk_vga);
      @(negedge clk_vga);

      // Reset state
      check("rst_hsync",   hs,   1'b1);
      check("rst_vsync",   vs,   1'b1);
      check("rst_video",   von,  1'b0);
      check("rst_busy",    busy, 1'b0);
      check("rst_err",     err,  1'b0);
      check("rst_px",      px,   12'd0);
      check("rst_p_hsync", p_hs, 1'b0);
      rst_vga_n = 1'b1;
      clk_n = 0;

      // Test 1: first frame after release
      goto(1);  check("t1_hs_c1", hs, 1'b0); check("t1_vs_c1", vs, 1'b0);
                check("t1_p_hs_c1", p_hs, 1'b0);
      goto(2);  check("t1_hs_c2", hs, 1'b0);
      goto(3);  check("t1_hs_c3", hs, 1'b1); check("t1_p_hs_c3", p_hs, 1'b1);
      goto(5);  check("t1_p_hs_c5", p_hs, 1'b0); check("t1_p_vs_c5", p_vs, 1'b1);
      goto(8);  check("t1_vs_c8", vs, 1'b0);
      goto(9);  check("t1_vs_c9", vs, 1'b1);
      goto(19); check("t1_von_c19", von, 1'b0);
      goto(20); check("t1_von_c20", von, 1'b1); check("t1_fp_c20", fp, 1'b1);
                check("t1_ls_c20", ls, 1'b1);   check("t1_px_c20", px, 12'd0);
                check("t1_py_c20", py, 11'd0);
      goto(21); check("t1_px_c21", px, 12'd1); check("t1_fp_c21", fp, 1'b0);
                check("t1_ls_c21", ls, 1'b0);
      goto(22); check("t1_p_fp_c22", p_fp, 1'b1);
      goto(23); check("t1_px_c23", px, 12'd3);
      goto(24); check("t1_von_c24", von, 1'b0); check("t1_px_c24", px, 12'd0);
      goto(28); check("t1_ls_c28", ls, 1'b1); check("t1_py_c28", py, 11'd1);
                check("t1_fp_c28", fp, 1'b0);
      goto(47); check("t1_fe_c47", fe, 1'b0);
      goto(48); check("t1_fe_c48", fe, 1'b1);

      // Test 2: one full frame of strobes
      n_von = 0; n_ls = 0; n_fp = 0; n_fe = 0;
      for (int k = 49; k <= 96; k++) begin
         goto(k);
         n_von += int'(von);
         n_ls  += int'(ls);
         n_fp  += int'(fp);
         n_fe  += int'(fe);
      end
      check("t2_video_cnt", n_von, 12);
      check("t2_line_cnt",  n_ls,  3);
      check("t2_first_cnt", n_fp,  1);
      check("t2_fend_cnt",  n_fe,  1);
      check("t2_fe_c96",    fe,    1'b1);

      // Test 3: HVA=8 loaded mid-frame, applied at the next frame boundary
      goto(100);
      set_cfg(8, 1, 2, 1, 3, 1, 1, 1);
      cfg_load = 1'b1;
      goto(101); cfg_load = 1'b0;
                 check("t3_busy_c101", busy, 1'b1); check("t3_err_c101", err, 1'b0);
      goto(116); check("t3_ls_old", ls, 1'b1);
      goto(143); check("t3_busy_c143", busy, 1'b1);
      goto(144); check("t3_fe_c144", fe, 1'b1); check("t3_busy_c144", busy, 1'b0);
      goto(172); check("t3_fp_c172", fp, 1'b1);
      goto(179); check("t3_px_c179", px, 12'd7);
      goto(180); check("t3_von_c180", von, 1'b0);

      // Test 4: rejected load (vsp=0)
      set_cfg(4, 1, 2, 1, 3, 1, 0, 1);
      cfg_load = 1'b1;
      goto(181); cfg_load = 1'b0;
                 check("t4_err_c181", err, 1'b1); check("t4_busy_c181", busy, 1'b0);
      goto(182); check("t4_err_c182", err, 1'b0);
      goto(215); check("t4_fe_c215", fe, 1'b0);
      goto(216); check("t4_fe_c216", fe, 1'b1); check("t4_busy_c216", busy, 1'b0);
      goto(244); check("t4_fp_c244", fp, 1'b1);

      // Test 5: load A pending, load B on the exact frame_end cycle
      goto(250);
      set_cfg(4, 1, 2, 1, 3, 1, 1, 1);
      cfg_load = 1'b1;
      goto(251); cfg_load = 1'b0; check("t5_busy_a", busy, 1'b1);
      goto(287);
      set_cfg(6, 1, 2, 1, 3, 1, 1, 1);
      cfg_load = 1'b1;
      goto(288); cfg_load = 1'b0;
                 check("t5_fe_c288", fe, 1'b1); check("t5_busy_c288", busy, 1'b1);
      goto(308); check("t5_fp_a", fp, 1'b1);
      goto(311); check("t5_px_a", px, 12'd3);
      goto(312); check("t5_von_a", von, 1'b0);
      goto(335); check("t5_busy_c335", busy, 1'b1); check("t5_fe_c335", fe, 1'b0);
      goto(336); check("t5_fe_c336", fe, 1'b1); check("t5_busy_c336", busy, 1'b0);

      // Test 6: pending load, then reset mid-visible
      goto(350);
      set_cfg(8, 1, 2, 1, 3, 1, 1, 1);
      cfg_load = 1'b1;
      goto(351); cfg_load = 1'b0; check("t6_busy_pend", busy, 1'b1);
      goto(360); check("t5_fp_b", fp, 1'b1);
      goto(362); check("t6_px_c362", px, 12'd2); check("t6_von_c362", von, 1'b1);
      rst_vga_n = 1'b0;
      goto(363);
      check("t6_rst_hs",   hs,   1'b1);
      check("t6_rst_vs",   vs,   1'b1);
      check("t6_rst_von",  von,  1'b0);
      check("t6_rst_busy", busy, 1'b0);
      check("t6_rst_px",   px,   12'd0);
      check("t6_rst_p_hs", p_hs, 1'b0);
      rst_vga_n = 1'b1;
      clk_n = 0;
      goto(1);  check("t6_hs_c1", hs, 1'b0);
      goto(20); check("t6_fp_c20", fp, 1'b1);
      goto(22); check("t6_p_fp_c22", p_fp, 1'b1);
      goto(23); check("t6_px_c23", px, 12'd3);
      goto(24); check("t6_von_c24", von, 1'b0);
      goto(48); check("t6_fe_c48", fe, 1'b1); check("t6_busy_c48", busy, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
